// File: rtl/tpu_tile_sequencer.sv
// Job-level sequencer for the TPU datapath: per tile it pops one weight set,
// pulses a systolic weight reload, streams cfg_rows unified-buffer reads and
// writes each result row to the result SRAM RESULT_LAT cycles after its read.
//
// Ports:
//   clk, rstn                      clock, synchronous active-low reset
//   start, abort                   job start (IDLE only) / synchronous abort
//   cfg_num_tiles, cfg_rows        job shape, latched on the start cycle
//   cfg_src_base, cfg_dst_base     first UB read / result write address
//   fifo_empty, fifo_read_enable   weight FIFO status / pop
//   we_rl                          systolic weight reload strobe
//   ub_read_enable, ub_address     UB row read strobe and address
//   res_write_enable, res_address  result SRAM write strobe and address
//   tile_idx, busy, done           progress, activity, job-complete pulse
//   perf_cycles, perf_wstall       busy / weight-stall cycle counters
//
// Optional feature: define TPU_SEQ_PERF_EN to build in the perf counters.
module tpu_tile_sequencer #(
  parameter int unsigned ADDRESSSIZE = 10,
  parameter int unsigned TILE_BW     = 4,
  parameter int unsigned RESULT_LAT  = 130
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start,
  input  logic                   abort,
  input  logic [TILE_BW-1:0]     cfg_num_tiles,
  input  logic [ADDRESSSIZE-1:0] cfg_rows,
  input  logic [ADDRESSSIZE-1:0] cfg_src_base,
  input  logic [ADDRESSSIZE-1:0] cfg_dst_base,
  input  logic                   fifo_empty,
  output logic                   fifo_read_enable,
  output logic                   we_rl,
  output logic                   ub_read_enable,
  output logic [ADDRESSSIZE-1:0] ub_address,
  output logic                   res_write_enable,
  output logic [ADDRESSSIZE-1:0] res_address,
  output logic [TILE_BW-1:0]     tile_idx,
  output logic                   busy,
  output logic                   done
`ifdef TPU_SEQ_PERF_EN
  , output logic [31:0]          perf_cycles
  , output logic [31:0]          perf_wstall
`endif
);

  localparam int unsigned AW  = ADDRESSSIZE;
  localparam int unsigned TW  = TILE_BW;
  localparam int unsigned LAT = RESULT_LAT;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_W, S_POP, S_RELOAD, S_STREAM, S_DRAIN, S_FINISH
  } state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   tiles_q, tiles_d;
  logic [AW-1:0]   rows_q, rows_d;
  logic [AW-1:0]   src_q, src_d;
  logic [AW-1:0]   dst_q, dst_d;
  logic [AW-1:0]   rd_cnt_q, rd_cnt_d;
  logic [AW-1:0]   wr_cnt_q, wr_cnt_d;
  logic [TW-1:0]   tile_q, tile_d;
  logic [LAT-1:0]  dl_q, dl_d;
  logic            fifo_re_q, fifo_re_d;
  logic            we_rl_q, we_rl_d;
  logic            ub_re_q, ub_re_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            res_we;
`ifdef TPU_SEQ_PERF_EN
  logic [31:0]     perf_cyc_q, perf_cyc_d;
  logic [31:0]     perf_ws_q, perf_ws_d;
`endif

  // The tail of the read-valid delay line is the write strobe.
  assign res_we = dl_q[LAT-1];

  // Next-state, counters and registered-output decode.
  always_comb begin
    state_d  = state_q;
    tiles_d  = tiles_q;
    rows_d   = rows_q;
    rd_cnt_d = rd_cnt_q;
    tile_d   = tile_q;
    dl_d     = (dl_q << 1) | LAT'(ub_re_q);
    src_d    = ub_re_q ? src_q + AW'(1) : src_q;
    dst_d    = res_we ? dst_q + AW'(1) : dst_q;
    wr_cnt_d = res_we ? wr_cnt_q + AW'(1) : wr_cnt_q;
`ifdef TPU_SEQ_PERF_EN
    perf_cyc_d = perf_cyc_q;
    perf_ws_d  = perf_ws_q;
    if (state_q != S_IDLE && perf_cyc_q != '1) perf_cyc_d = perf_cyc_q + 32'd1;
    if (state_q == S_WAIT_W && fifo_empty && perf_ws_q != '1) perf_ws_d = perf_ws_q + 32'd1;
`endif

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          tiles_d  = cfg_num_tiles;
          rows_d   = cfg_rows;
          src_d    = cfg_src_base;
          dst_d    = cfg_dst_base;
          tile_d   = '0;
          rd_cnt_d = '0;
          wr_cnt_d = '0;
          state_d  = (cfg_num_tiles != '0 && cfg_rows != '0) ? S_WAIT_W : S_FINISH;
`ifdef TPU_SEQ_PERF_EN
          perf_cyc_d = '0;
          perf_ws_d  = '0;
`endif
        end
      end
      S_WAIT_W: if (!fifo_empty) state_d = S_POP;
      S_POP:    state_d = S_RELOAD;
      S_RELOAD: begin
        rd_cnt_d = '0;
        state_d  = S_STREAM;
      end
      S_STREAM: begin
        if (rd_cnt_q == rows_q - AW'(1)) state_d = S_DRAIN;
        else rd_cnt_d = rd_cnt_q + AW'(1);
      end
      // Leave on the cycle that carries this tile's last result write.
      S_DRAIN: begin
        if (res_we && wr_cnt_q == rows_q - AW'(1)) begin
          wr_cnt_d = '0;
          if (tile_q == tiles_q - TW'(1)) begin
            state_d = S_FINISH;
          end else begin
            tile_d  = tile_q + TW'(1);
            state_d = S_WAIT_W;
          end
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Abort overrides everything and drops all in-flight result writes.
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      dl_d    = '0;
    end

    fifo_re_d = (state_d == S_POP);
    we_rl_d   = (state_d == S_RELOAD);
    ub_re_d   = (state_d == S_STREAM);
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_FINISH);
  end

  // All state, counters and outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      tiles_q   <= '0;
      rows_q    <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      tile_q    <= '0;
      dl_q      <= '0;
      fifo_re_q <= 1'b0;
      we_rl_q   <= 1'b0;
      ub_re_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef TPU_SEQ_PERF_EN
      perf_cyc_q <= '0;
      perf_ws_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      tiles_q   <= tiles_d;
      rows_q    <= rows_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      tile_q    <= tile_d;
      dl_q      <= dl_d;
      fifo_re_q <= fifo_re_d;
      we_rl_q   <= we_rl_d;
      ub_re_q   <= ub_re_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef TPU_SEQ_PERF_EN
      perf_cyc_q <= perf_cyc_d;
      perf_ws_q  <= perf_ws_d;
`endif
    end
  end

  assign fifo_read_enable = fifo_re_q;
  assign we_rl            = we_rl_q;
  assign ub_read_enable   = ub_re_q;
  assign ub_address       = src_q;
  assign res_write_enable = res_we;
  assign res_address      = dst_q;
  assign tile_idx         = tile_q;
  assign busy             = busy_q;
  assign done             = done_q;
`ifdef TPU_SEQ_PERF_EN
  assign perf_cycles      = perf_cyc_q;
  assign perf_wstall      = perf_ws_q;
`endif

endmodule

// File: doc/tpu_tile_sequencer.md
Name: tpu_tile_sequencer

Overview:
- Job-level controller for the TPU datapath.
- On `start` it runs `cfg_num_tiles` tiles. Per tile: pop one weight set from the weight FIFO, pulse weight reload into the systolic array, stream `cfg_rows` input rows from the unified buffer, then write each result row to the result SRAM exactly `RESULT_LAT` cycles after its read.
- Replaces the free-running result counter and fixed-length state counter with a parametrised, handshaked sequencer: base addresses, tile count, abort and a done pulse.

Parameters:
- ADDRESSSIZE, 10, width of the UB and result SRAM addresses and of the row count.
- TILE_BW, 4, width of the tile count.
- RESULT_LAT, 130, cycles from a UB read to its result row being valid at the result SRAM input. Must be >= 1.

Ports:
- clk  input  1  clock
- rstn  input  1  synchronous active-low reset
- start  input  1  job start; sampled only in IDLE
- abort  input  1  synchronous job abort
- cfg_num_tiles  input  TILE_BW  tiles per job
- cfg_rows  input  ADDRESSSIZE  input rows per tile
- cfg_src_base  input  ADDRESSSIZE  first UB read address
- cfg_dst_base  input  ADDRESSSIZE  first result write address
- fifo_empty  input  1  weight FIFO empty
- fifo_read_enable  output  1  weight FIFO pop
- we_rl  output  1  systolic weight reload
- ub_read_enable  output  1  UB row read strobe
- ub_address  output  ADDRESSSIZE  UB read address
- res_write_enable  output  1  result SRAM write
- res_address  output  ADDRESSSIZE  result write address
- tile_idx  output  TILE_BW  current tile, 0-based
- busy  output  1  job in progress
- done  output  1  one-cycle job-complete pulse

Behaviour:
- Clock and reset:
  - One clock, `clk`.
  - `rstn` is synchronous and active-low.
  - In reset: state is IDLE, the delay line is cleared, and all outputs are 0.
- Configuration: the cfg_* inputs are latched in the `start` cycle and are don't-care afterwards.
- States: IDLE, WAIT_W, POP, RELOAD, STREAM, DRAIN, FINISH. All outputs are decoded from registered state and counters.
- IDLE:
  - `start` = 1 with `cfg_num_tiles` != 0 and `cfg_rows` != 0 -> WAIT_W.
  - `start` = 1 with either count 0 -> FINISH. No pop, read or write occurs.
  - `start` while `busy` is ignored.
- WAIT_W: stay while `fifo_empty` = 1; otherwise -> POP.
- POP: `fifo_read_enable` = 1 for this single cycle -> RELOAD.
- RELOAD: `we_rl` = 1 for this single cycle -> STREAM.
- STREAM:
  - `ub_read_enable` = 1 for exactly `cfg_rows` consecutive cycles; `ub_address` increments by 1 per read.
  - The source pointer continues across tiles, so tile k reads from `cfg_src_base + k*cfg_rows`.
  - After the last read -> DRAIN.
- Result writes:
  - Each read pushes a 1 into a `RESULT_LAT`-deep valid delay line.
  - `res_write_enable` = the delay-line output, i.e. read in cycle t -> write in cycle t+`RESULT_LAT`.
  - `res_address` starts at `cfg_dst_base` and increments after every write, continuing across tiles.
- DRAIN:
  - Exits at the end of the cycle in which the tile's final write is asserted.
  - Goes to WAIT_W with `tile_idx` + 1 if tiles remain, else to FINISH.
- FINISH: `done` = 1 for one cycle -> IDLE.
- `busy` = 1 in every state except IDLE, including FINISH.
- Address arithmetic: addresses wrap modulo 2^ADDRESSSIZE with no error.
- Abort:
  - `abort` = 1 in any non-IDLE state -> IDLE next cycle.
  - The delay line is cleared, so no further writes occur.
  - `done` is not pulsed.
  - `abort` has priority over all other transitions; `abort` in IDLE is ignored.
  - `start` and `abort` together in IDLE: `abort` wins and the job is not started.
- Reset mid-job: identical to abort, plus all outputs forced to 0.

Optional Feature:
- Macro: TPU_SEQ_PERF_EN.
- When defined, two extra outputs are compiled in:
  - `perf_cycles[31:0]`: counts cycles with `busy` = 1 during the current job, cleared on accepted `start`, holds after `done`.
  - `perf_wstall[31:0]`: counts cycles spent in WAIT_W with `fifo_empty` = 1.
  - Both counters saturate at all-ones and reset to 0.
- When undefined: neither port nor counter exists, and behaviour is otherwise identical.

Test Plan:
- Two tiles, 3 rows, `RESULT_LAT` = 4, src = 0x010, dst = 0x200, FIFO never empty, `start` sampled in cycle 0:
  - `fifo_read_enable` in cycles 2 and 12; `we_rl` in 3 and 13.
  - Reads at 4-6 (0x010-0x012) and 14-16 (0x013-0x015).
  - Writes at 8-10 (0x200-0x202) and 18-20 (0x203-0x205).
  - `done` in cycle 21; `busy` = 0 from cycle 22.
- `fifo_empty` held 1 for 5 cycles after WAIT_W entry:
  - POP delayed exactly 5 cycles.
  - With TPU_SEQ_PERF_EN, `perf_wstall` = 5.
- src = 0x3FE, 4 rows, 1 tile, `ADDRESSSIZE` = 10: reads 0x3FE, 0x3FF, 0x000, 0x001.
- `abort` one cycle after the second read of a 3-row tile:
  - IDLE next cycle; no `res_write_enable` ever asserts; no `done`.
  - A following `start` runs a clean job.
- `cfg_num_tiles` = 0: `done` one cycle after `start`, `busy` = 1 for that cycle only, no pop/read/write.
- `start` pulsed mid-job: ignored, job result identical to the single-start run. `rstn` low mid-STREAM: all outputs 0 next cycle.
